// File: rtl/down_cnt_reload_pkg.sv
// Shared state encoding for the reloadable down-counter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package down_cnt_reload_pkg;

  // Two-state control: IDLE holds the count, RUN counts down on CE.
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

endpackage

// File: rtl/down_cnt_reload.sv
// Programmable down-counting rate generator with double-buffered period and one-shot mode.
// Latency: Q/DONE registered (1 cycle after the causing edge); BO is combinational in the same cycle.
// Backpressure: none; CE gates every count step, STOP/START override counting.
module down_cnt_reload
  import down_cnt_reload_pkg::*;
#(
  parameter int W            = 16,
  parameter int RESET_PERIOD = 1
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         CE,
  input  logic [W-1:0] PERIOD,
  input  logic         PERIOD_WE,
  input  logic         START,
  input  logic         STOP,
  input  logic         ONESHOT,
  output logic [W-1:0] Q,
  output logic         BO,
  output logic         BUSY,
  output logic         DONE
);

  logic         r_state;
  logic [W-1:0] r_q;
  logic [W-1:0] r_shadow;
  logic         r_mode_os;
  logic         r_done;

  logic [W-1:0] w_eff;
  logic         w_q_zero;

  // Reload value for a period of P ticks; P=0 is treated as P=1 so the
  // counter never has to represent a negative start point.
  function automatic logic [W-1:0] load_val(input logic [W-1:0] p);
    return (p == '0) ? '0 : (p - W'(1));
  endfunction

  // A period written in the same cycle as a load is used immediately,
  // otherwise the buffered shadow value applies.
  assign w_eff    = PERIOD_WE ? PERIOD : r_shadow;
  assign w_q_zero = (r_q == '0);

  // Borrow is only meaningful for a real count step in RUN; STOP and
  // START both pre-empt the step, so they also suppress the borrow.
  assign BO   = (r_state == ST_RUN) & CE & w_q_zero & ~STOP & ~START;
  assign BUSY = (r_state == ST_RUN);
  assign Q    = r_q;
  assign DONE = r_done;

  // Control state, count, shadow period and one-shot completion pulse.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state   <= ST_IDLE;
      r_q       <= '0;
      r_shadow  <= W'(RESET_PERIOD);
      r_mode_os <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // The shadow only feeds future loads; it never touches the live count.
      if (PERIOD_WE) begin
        r_shadow <= PERIOD;
      end
      case (r_state)
        ST_IDLE: begin
          if (START && !STOP) begin
            r_state   <= ST_RUN;
            r_q       <= load_val(w_eff);
            r_mode_os <= ONESHOT;
          end
        end
        default: begin
          if (STOP) begin
            r_state <= ST_IDLE;
          end else if (START) begin
            r_q       <= load_val(w_eff);
            r_mode_os <= ONESHOT;
          end else if (CE) begin
            if (!w_q_zero) begin
              r_q <= r_q - W'(1);
            end else if (r_mode_os) begin
              r_q     <= '0;
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_q <= load_val(w_eff);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_down_cnt_reload.sv
// Directed self-checking bench for down_cnt_reload (W=16, RESET_PERIOD=1).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_down_cnt_reload;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        CE;
  logic [15:0] PERIOD;
  logic        PERIOD_WE;
  logic        START;
  logic        STOP;
  logic        ONESHOT;
  logic [15:0] Q;
  logic        BO;
  logic        BUSY;
  logic        DONE;

  int n_chk  = 0;
  int n_fail = 0;

  down_cnt_reload #(.W(16), .RESET_PERIOD(1)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .CE        (CE),
    .PERIOD    (PERIOD),
    .PERIOD_WE (PERIOD_WE),
    .START     (START),
    .STOP      (STOP),
    .ONESHOT   (ONESHOT),
    .Q         (Q),
    .BO        (BO),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, settle, then return for checks.
  task automatic drv(input logic ce, input logic st, input logic sp,
                     input logic we, input logic [15:0] p, input logic os);
    @(negedge CLK);
    CE = ce; START = st; STOP = sp; PERIOD_WE = we; PERIOD = p; ONESHOT = os;
    #1;
  endtask

  // Expected sequences, worked out by hand from the counter rules.
  logic [15:0] exp_q3 [12] = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1,
                               16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1};
  logic [15:0] exp_q4 [9]  = '{16'd4, 16'd3, 16'd2, 16'd1, 16'd0,
                               16'd1, 16'd0, 16'd1, 16'd0};

  initial begin
    RST_N = 1'b0; CE = 1'b0; START = 1'b0; STOP = 1'b0;
    PERIOD_WE = 1'b0; PERIOD = '0; ONESHOT = 1'b0;

    // Reset state
    drv(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    drv(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    chk("rst_q", 32'(Q), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_bo", 32'(BO), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    RST_N = 1'b1;

    // P=1 from reset shadow: BO every CE cycle, Q stays 0
    drv(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    chk("p1_start_bo", 32'(BO), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
      chk("p1_q", 32'(Q), 32'd0);
      chk("p1_bo", 32'(BO), 32'd1);
      chk("p1_busy", 32'(BUSY), 32'd1);
    end

    // Write P=4 into shadow while running with CE=0: count holds
    drv(1'b0, 1'b0, 1'b0, 1'b1, 16'd4, 1'b0);
    chk("we_noce_bo", 32'(BO), 32'd0);
    // Restart with CE=1 at Q==0: START suppresses BO
    drv(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    chk("restart_q_before", 32'(Q), 32'd0);
    chk("restart_bo", 32'(BO), 32'd0);
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
      chk("p4_q", 32'(Q), 32'(3 - (i % 4)));
      chk("p4_bo", 32'(BO), ((i % 4) == 3) ? 32'd1 : 32'd0);
    end

    // P=2 with CE every third cycle: BO spacing 6 clocks
    drv(1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 1'b0);
    for (int i = 0; i < 12; i++) begin
      drv(((i % 3) == 0), 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
      chk("ce3_q", 32'(Q), 32'(exp_q3[i]));
      chk("ce3_bo", 32'(BO), (i == 3 || i == 9) ? 32'd1 : 32'd0);
    end

    // P=5 running, write P=2 at Q=3: current period completes first
    drv(1'b0, 1'b1, 1'b0, 1'b1, 16'd5, 1'b0);
    for (int i = 0; i < 9; i++) begin
      drv(1'b1, 1'b0, 1'b0, (i == 1), (i == 1) ? 16'd2 : 16'd0, 1'b0);
      chk("upd_q", 32'(Q), 32'(exp_q4[i]));
      chk("upd_bo", 32'(BO), (i == 4 || i == 6 || i == 8) ? 32'd1 : 32'd0);
    end

    // One-shot P=3
    drv(1'b0, 1'b1, 1'b0, 1'b1, 16'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
      chk("os_q", 32'(Q), 32'(2 - i));
      chk("os_bo", 32'(BO), (i == 2) ? 32'd1 : 32'd0);
      chk("os_busy", 32'(BUSY), 32'd1);
      chk("os_done_early", 32'(DONE), 32'd0);
    end
    drv(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    chk("os_done", 32'(DONE), 32'd1);
    chk("os_idle_busy", 32'(BUSY), 32'd0);
    chk("os_idle_q", 32'(Q), 32'd0);
    chk("os_idle_bo", 32'(BO), 32'd0);
    drv(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    chk("os_done_clr", 32'(DONE), 32'd0);
    chk("os_after_bo", 32'(BO), 32'd0);

    // STOP with CE at Q==0: no BO, back to IDLE
    drv(1'b0, 1'b1, 1'b0, 1'b1, 16'd1, 1'b0);
    drv(1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    chk("stop_q", 32'(Q), 32'd0);
    chk("stop_bo", 32'(BO), 32'd0);
    drv(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    chk("stop_busy", 32'(BUSY), 32'd0);
    chk("stop_idle_bo", 32'(BO), 32'd0);

    // START and PERIOD_WE(7) in the same cycle
    drv(1'b0, 1'b1, 1'b0, 1'b1, 16'd7, 1'b0);
    drv(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    chk("sw7_q", 32'(Q), 32'd6);
    chk("sw7_busy", 32'(BUSY), 32'd1);
    drv(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    chk("sw7_q5", 32'(Q), 32'd5);

    // Reset mid-run at Q=4
    drv(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    chk("rr_q4", 32'(Q), 32'd4);
    RST_N = 1'b0;
    drv(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    RST_N = 1'b1;
    chk("rr_q", 32'(Q), 32'd0);
    chk("rr_busy", 32'(BUSY), 32'd0);
    // Shadow back to RESET_PERIOD=1: START without write loads 0, BO every CE
    drv(1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    drv(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    chk("rr_shadow_q", 32'(Q), 32'd0);
    chk("rr_shadow_bo", 32'(BO), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
